// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
//            for the 10 MHz / 115200 baud link. The serial input is
//            synchronised, sampled mid-bit with a clock-count divider, and
//            good bytes are pushed into a small show-ahead FIFO that is read
//            with a valid/read handshake.
// Ports    : clk10mhz   in   system clock, rising edge
//            rst        in   synchronous active-high reset
//            uRx        in   asynchronous serial input, idles high
//            rxData8    out  FIFO head byte (0 while empty)
//            rxValid    out  FIFO not empty
//            rxRead     in   pop head when rxValid=1
//            rxBusy     out  a frame is being received
//            frameErr   out  one-cycle pulse on bad stop (or parity) bit
//            rxOverflow out  sticky: good byte arrived with FIFO full
// Config   : `define UART_RX_PARITY_EN to build the 8E1 (even parity) variant.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk10mhz,
  input  logic       rst,
  input  logic       uRx,
  output logic [7:0] rxData8,
  output logic       rxValid,
  input  logic       rxRead,
  output logic       rxBusy,
  output logic       frameErr,
  output logic       rxOverflow
);

  localparam int c_DIV_W = $clog2(CLKS_PER_BIT);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  // Start bit is checked near its middle; odd bit periods round the half up.
  localparam logic [c_DIV_W-1:0] c_HALF_CNT = c_DIV_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [c_DIV_W-1:0] c_FULL_CNT = c_DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
  localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic               rx_meta_q;
  logic               rxS_q;
  logic               rx_prev_q;
  state_t             state_q;
  logic [c_DIV_W-1:0] div_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic               frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic               par_err_q;
`endif

  logic w_tick;
  logic w_push;

  assign w_tick = (div_q == c_FULL_CNT);

`ifdef UART_RX_PARITY_EN
  assign w_push = (state_q == S_STOP) && w_tick && rxS_q && !par_err_q;
`else
  assign w_push = (state_q == S_STOP) && w_tick && rxS_q;
`endif

  always_ff @(posedge clk10mhz) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxS_q       <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= uRx;
      rxS_q       <= rx_meta_q;
      rx_prev_q   <= rxS_q;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          div_q     <= '0;
          bit_cnt_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
          par_err_q <= 1'b0;
`endif
          if (rx_prev_q && !rxS_q) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (div_q == c_HALF_CNT) begin
            div_q   <= '0;
            // A line that is already high again was only a glitch.
            state_q <= rxS_q ? S_IDLE : S_DATA;
          end else begin
            div_q <= div_q + c_DIV_ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            div_q     <= '0;
            shift_q   <= {rxS_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            div_q <= div_q + c_DIV_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            div_q     <= '0;
            par_err_q <= ^{shift_q, rxS_q};
            state_q   <= S_STOP;
          end else begin
            div_q <= div_q + c_DIV_ONE;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            div_q <= '0;
            if (rxS_q) begin
              // Straight back to IDLE so a back-to-back start edge is seen.
              state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              frame_err_q <= par_err_q;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            div_q <= div_q + c_DIV_ONE;
          end
        end
        S_BREAK: begin
          // Hold here until the line is released so a stuck-low line
          // cannot produce a stream of bogus frames.
          if (rxS_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic w_pop;
  logic w_full;
  logic w_wr;

  always_comb begin
    w_pop    = rxRead && (count_q != '0);
    w_full   = (count_q == c_DEPTH);
    // A pop in the same cycle frees the slot the new byte needs.
    w_wr     = w_push && (!w_full || w_pop);
    wr_ptr_d = w_wr  ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
    rd_ptr_d = w_pop ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    if (w_wr && !w_pop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (!w_wr && w_pop) begin
      count_d = count_q - c_CNT_ONE;
    end
    ovf_d = ovf_q | (w_push && w_full && !w_pop);
  end

  always_ff @(posedge clk10mhz) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: an entry is only visible after it is written.
  always_ff @(posedge clk10mhz) begin
    if (!rst && w_wr) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rxValid    = (count_q != '0);
  assign rxData8    = rxValid ? mem_q[rd_ptr_q] : 8'h00;
  assign rxBusy     = (state_q != S_IDLE);
  assign frameErr   = frame_err_q;
  assign rxOverflow = ovf_q;

endmodule
`default_nettype wire
